// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings, slave FSM states and lane helper.
// Imported by ahb_sram_slave and ahb_sram_mem.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Byte enables for a transfer of the given size at byte offset off.
    function automatic logic [3:0] lane_mask(
        input logic [2:0] size,
        input logic [1:0] off
    );
        logic [3:0] m;
        unique case (1'b1)
            (size == HSIZE_BYTE): m = 4'b0001 << off;
            (size == HSIZE_HALF): m = off[1] ? 4'b1100 : 4'b0011;
            default:              m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// ahb_sram_mem: word array with byte-lane writes and async read.
// Ports: clk, rst_n, we, idx, be, wdata -> rdata (word at idx).
module ahb_sram_mem
    import ahb_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [IW-1:0] idx,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM slave, two-cycle ERROR on illegal access.
// Ports: hclk, hresetn, AHB address/data inputs; hreadyout_o, hrdata_o, hresp_o.
// Macro AHB_SLAVE_WAIT_EN adds WAIT_CYCLES wait states to legal transfers.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int MEM_DEPTH      = 64,
    parameter int WAIT_CYCLES    = 2
) (
    input  logic                      hclk,
    input  logic                      hresetn,
    input  logic                      hsel_i,
    input  logic [AHB_ADDR_WIDTH-1:0] haddr_i,
    input  logic [1:0]                htrans_i,
    input  logic                      hwrite_i,
    input  logic [2:0]                hsize_i,
    input  logic [2:0]                hburst_i,
    input  logic [3:0]                hprot_i,
    input  logic [31:0]               hwdata_i,
    input  logic                      hready_i,
    output logic                      hreadyout_o,
    output logic [31:0]               hrdata_o,
    output logic [1:0]                hresp_o
);

    localparam int AW = AHB_ADDR_WIDTH;
    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    state_e        state_q, state_d;
    logic          dphase_q, dphase_d;
    logic          write_q;
    logic [3:0]    be_q;
    logic [IW-1:0] idx_q;
    logic          accept, legal, done, we;
    logic [31:0]   rdata;
    logic          unused_ok;

    assign unused_ok = ^{hburst_i, hprot_i, (WAIT_CYCLES != 0)};

    // Only IDLE and ERR2 drive hreadyout high, so only they take a new address.
    assign accept = hsel_i & hready_i
                  & ((htrans_i == HTRANS_NONSEQ) | (htrans_i == HTRANS_SEQ))
                  & ((state_q == ST_IDLE) | (state_q == ST_ERR2));

    always_comb begin
        legal = 1'b1;
        if (hsize_i > HSIZE_WORD) legal = 1'b0;
        if (hsize_i == HSIZE_HALF && haddr_i[0]) legal = 1'b0;
        if (hsize_i == HSIZE_WORD && haddr_i[1:0] != 2'b00) legal = 1'b0;
        if ({2'b00, haddr_i[AW-1:2]} >= AW'(MEM_DEPTH)) legal = 1'b0;
    end

    // A legal data phase finishes in IDLE once any waits have elapsed.
    assign done = (state_q == ST_IDLE) & dphase_q;
    assign we   = done & write_q;

`ifdef AHB_SLAVE_WAIT_EN
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`endif

    always_comb begin
        state_d     = state_q;
        dphase_d    = 1'b0;
        hreadyout_o = 1'b1;
        hresp_o     = HRESP_OKAY;
`ifdef AHB_SLAVE_WAIT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (state_q == ST_ERR2) begin
                    hresp_o = HRESP_ERROR;
                    state_d = ST_IDLE;
                end
                if (accept) begin
                    if (!legal) begin
                        state_d = ST_ERR1;
                    end else begin
                        dphase_d = 1'b1;
`ifdef AHB_SLAVE_WAIT_EN
                        if (WAIT_CYCLES > 0) begin
                            state_d = ST_WAIT;
                            cnt_d   = CW'(WAIT_CYCLES - 1);
                        end
`endif
                    end
                end
            end
`ifdef AHB_SLAVE_WAIT_EN
            ST_WAIT: begin
                hreadyout_o = 1'b0;
                dphase_d    = 1'b1;
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
`endif
            ST_ERR1: begin
                hreadyout_o = 1'b0;
                hresp_o     = HRESP_ERROR;
                state_d     = ST_ERR2;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q  <= ST_IDLE;
            dphase_q <= 1'b0;
            write_q  <= 1'b0;
            be_q     <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            dphase_q <= dphase_d;
            if (accept) begin
                write_q <= hwrite_i;
                be_q    <= lane_mask(hsize_i, haddr_i[1:0]);
                idx_q   <= haddr_i[IW+1:2];
            end
        end
    end

    ahb_sram_mem #(
        .DEPTH (MEM_DEPTH),
        .IW    (IW)
    ) u_mem (
        .clk   (hclk),
        .rst_n (hresetn),
        .we    (we),
        .idx   (idx_q),
        .be    (be_q),
        .wdata (hwdata_i),
        .rdata (rdata)
    );

    assign hrdata_o = (done & ~write_q) ? rdata : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: scoreboard bench for ahb_sram_slave.
// Expected waits follow AHB_SLAVE_WAIT_EN (WAIT_CYCLES=2 when defined).
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    localparam int AW    = 32;
    localparam int DEPTH = 64;
`ifdef AHB_SLAVE_WAIT_EN
    localparam int EXP_WAITS = 2;
`else
    localparam int EXP_WAITS = 0;
`endif

    logic          hclk    = 1'b0;
    logic          hresetn = 1'b0;
    logic          hsel    = 1'b0;
    logic [AW-1:0] haddr   = '0;
    logic [1:0]    htrans  = HTRANS_IDLE;
    logic          hwrite  = 1'b0;
    logic [2:0]    hsize   = '0;
    logic [2:0]    hburst  = '0;
    logic [3:0]    hprot   = '0;
    logic [31:0]   hwdata  = '0;
    logic          hready;
    logic          hreadyout;
    logic [31:0]   hrdata;
    logic [1:0]    hresp;

    assign hready = hreadyout;

    always #5 hclk = ~hclk;

    ahb_sram_slave #(
        .AHB_ADDR_WIDTH (AW),
        .MEM_DEPTH      (DEPTH),
        .WAIT_CYCLES    (2)
    ) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .hsel_i      (hsel),
        .haddr_i     (haddr),
        .htrans_i    (htrans),
        .hwrite_i    (hwrite),
        .hsize_i     (hsize),
        .hburst_i    (hburst),
        .hprot_i     (hprot),
        .hwdata_i    (hwdata),
        .hready_i    (hready),
        .hreadyout_o (hreadyout),
        .hrdata_o    (hrdata),
        .hresp_o     (hresp)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [2:0]    size;
        logic [31:0]   wdata;
    } op_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          waits;
    } exp_t;

    op_t         ops[$];
    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    int          checks = 0;
    int          errors = 0;

    function automatic logic legal_of(input op_t o);
        if (o.size > 3'd2) return 1'b0;
        if (o.size == 3'd1 && o.addr[0]) return 1'b0;
        if (o.size == 3'd2 && o.addr[1:0] != 2'b00) return 1'b0;
        if ((o.addr >> 2) >= DEPTH) return 1'b0;
        return 1'b1;
    endfunction

    task automatic add(input logic wr, input logic [AW-1:0] addr,
                       input logic [2:0] size, input logic [31:0] wdata);
        op_t o;
        o.wr = wr; o.addr = addr; o.size = size; o.wdata = wdata;
        ops.push_back(o);
    endtask

    task automatic push_exp(input op_t o);
        exp_t e;
        logic lg;
        int w;
        bit hit;
        lg = legal_of(o);
        w = int'(o.addr >> 2);
        e.resp = lg ? HRESP_OKAY : HRESP_ERROR;
        e.waits = lg ? EXP_WAITS : 1;
        e.rdata = '0;
        if (lg && o.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (o.size == 3'd0) hit = (b == int'(o.addr[1:0]));
                else if (o.size == 3'd1) hit = ((b / 2) == int'(o.addr[1]));
                else hit = 1'b1;
                if (hit) model[w][8*b +: 8] = o.wdata[8*b +: 8];
            end
        end else if (lg) begin
            e.rdata = model[w];
        end
        sb.push_back(e);
    endtask

    task automatic drive(input int a, input int d, input int n);
        if (a < n) begin
            hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = ops[a].addr;
            hwrite = ops[a].wr; hsize = ops[a].size;
        end else begin
            hsel = 1'b0; htrans = HTRANS_IDLE; haddr = '0;
            hwrite = 1'b0; hsize = '0;
        end
        hwdata = (d >= 0 && ops[d].wr) ? ops[d].wdata : '0;
    endtask

    // Pipelined master: next address overlaps the current data phase.
    task automatic run();
        int a = 0;
        int d = -1;
        int n;
        int nw = 0;
        logic rdy;
        exp_t e;
        n = ops.size();
        drive(a, d, n);
        while (a < n || d >= 0) begin
            @(negedge hclk);
            rdy = hreadyout;
            if (d >= 0) begin
                e = sb[0];
                if (!rdy) begin
                    nw++;
                    checks++;
                    if (hresp !== e.resp || hrdata !== 32'h0) begin
                        errors++;
                        $display("FAIL wait_cycle op%0d resp=%b rdata=%h want resp=%b rdata=0",
                                 d, hresp, hrdata, e.resp);
                    end
                    if (nw > 20) begin
                        checks++;
                        errors++;
                        $display("FAIL timeout op%0d hreadyout stuck 0 want 1", d);
                        sb.delete();
                        ops.delete();
                        drive(0, -1, 0);
                        return;
                    end
                end else begin
                    void'(sb.pop_front());
                    checks++;
                    if (hresp !== e.resp) begin
                        errors++;
                        $display("FAIL resp op%0d got %b want %b", d, hresp, e.resp);
                    end
                    checks++;
                    if (hrdata !== e.rdata) begin
                        errors++;
                        $display("FAIL rdata op%0d got %h want %h", d, hrdata, e.rdata);
                    end
                    checks++;
                    if (nw !== e.waits) begin
                        errors++;
                        $display("FAIL waits op%0d got %0d want %0d", d, nw, e.waits);
                    end
                    nw = 0;
                end
            end
            @(posedge hclk);
            #1;
            if (rdy) begin
                if (a < n) begin
                    push_exp(ops[a]);
                    d = a;
                    a++;
                end else begin
                    d = -1;
                end
            end
            drive(a, d, n);
        end
        ops.delete();
    endtask

    task automatic test_reset();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        hresetn = 1'b0;
        repeat (2) @(negedge hclk);
        checks++;
        if (hreadyout !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", hreadyout);
        end
        checks++;
        if (hresp !== HRESP_OKAY) begin
            errors++;
            $display("FAIL reset_resp got %b want 00", hresp);
        end
        checks++;
        if (hrdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h want 0", hrdata);
        end
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
    endtask

    task automatic test_idle();
        logic [1:0] tr [3];
        logic       sl [3];
        tr[0] = HTRANS_IDLE;   sl[0] = 1'b1;
        tr[1] = HTRANS_BUSY;   sl[1] = 1'b1;
        tr[2] = HTRANS_NONSEQ; sl[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hsel = sl[i]; htrans = tr[i]; hwrite = 1'b1;
            hsize = HSIZE_WORD; haddr = 32'h30;
            @(posedge hclk);
            #1;
            hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
            hwdata = 32'h5A5A5A5A;
            @(negedge hclk);
            checks++;
            if (hreadyout !== 1'b1 || hresp !== HRESP_OKAY) begin
                errors++;
                $display("FAIL idle_resp case%0d ready=%b resp=%b want 1/00",
                         i, hreadyout, hresp);
            end
            @(posedge hclk);
            #1;
            hwdata = '0;
        end
        add(1'b0, 32'h30, HSIZE_WORD, '0);
        run();
    endtask

    task automatic test_word();
        add(1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF);
        add(1'b0, 32'h10, HSIZE_WORD, '0);
        add(1'b1, 32'h14, HSIZE_WORD, 32'h0BADF00D);
        add(1'b0, 32'h14, HSIZE_WORD, '0);
        add(1'b1, 32'hFC, HSIZE_WORD, 32'hA5A5C3C3);
        add(1'b0, 32'hFC, HSIZE_WORD, '0);
        run();
    endtask

    task automatic test_lanes();
        add(1'b1, 32'h10, HSIZE_WORD, 32'h11223344);
        add(1'b1, 32'h13, HSIZE_BYTE, 32'hAA000000);
        add(1'b0, 32'h10, HSIZE_WORD, '0);
        add(1'b1, 32'h08, HSIZE_WORD, 32'h01020304);
        add(1'b1, 32'h0A, HSIZE_HALF, 32'h55660000);
        add(1'b1, 32'h09, HSIZE_BYTE, 32'h0000EE00);
        add(1'b0, 32'h0A, HSIZE_HALF, '0);
        add(1'b0, 32'h13, HSIZE_BYTE, '0);
        run();
    endtask

    task automatic test_error();
        add(1'b0, 32'h01,  HSIZE_HALF, '0);
        add(1'b0, 32'h100, HSIZE_WORD, '0);
        add(1'b1, 32'h100, HSIZE_WORD, 32'hFFFFFFFF);
        add(1'b1, 32'h12,  HSIZE_WORD, 32'hFFFFFFFF);
        add(1'b1, 32'h10,  3'b011,     32'hFFFFFFFF);
        add(1'b0, 32'h10,  HSIZE_WORD, '0);
        add(1'b0, 32'h00,  HSIZE_WORD, '0);
        add(1'b0, 32'h12,  HSIZE_HALF, '0);
        run();
    endtask

    task automatic test_back_to_back();
        add(1'b1, 32'h40, HSIZE_WORD, 32'hCAFE0001);
        add(1'b1, 32'h44, HSIZE_WORD, 32'hCAFE0002);
        add(1'b0, 32'h40, HSIZE_WORD, '0);
        add(1'b0, 32'h44, HSIZE_WORD, '0);
        add(1'b0, 32'h10, HSIZE_WORD, '0);
        add(1'b0, 32'h08, HSIZE_WORD, '0);
        run();
    endtask

    task automatic test_reset_mid();
        int n;
        hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1;
        hsize = HSIZE_WORD; haddr = 32'h20;
        @(posedge hclk);
        #1;
        hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
        hwdata = 32'hCAFEF00D;
        #2;
        hresetn = 1'b0;
        #1;
        checks++;
        if (hreadyout !== 1'b1 || hresp !== HRESP_OKAY || hrdata !== 32'h0) begin
            errors++;
            $display("FAIL midreset_out ready=%b resp=%b rdata=%h want 1/00/0",
                     hreadyout, hresp, hrdata);
        end
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        hwdata = '0;
        // Single-edge address phase right after release must be taken.
        hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1;
        hsize = HSIZE_WORD; haddr = 32'h04;
        @(posedge hclk);
        #1;
        hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
        hwdata = 32'h12345678;
        n = 0;
        @(negedge hclk);
        while (hreadyout !== 1'b1 && n < 20) begin
            n++;
            @(negedge hclk);
        end
        checks++;
        if (n !== EXP_WAITS) begin
            errors++;
            $display("FAIL first_edge_waits got %0d want %0d", n, EXP_WAITS);
        end
        model[1] = 32'h12345678;
        @(posedge hclk);
        #1;
        hwdata = '0;
        add(1'b0, 32'h20, HSIZE_WORD, '0);
        add(1'b0, 32'h04, HSIZE_WORD, '0);
        add(1'b0, 32'h10, HSIZE_WORD, '0);
        run();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_idle();
        test_word();
        test_lanes();
        test_error();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge hclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter AHB_ADDR_WIDTH, default 32: haddr_i width.
REQ-002 SHALL have parameter MEM_DEPTH, default 64: number of 32-bit words stored.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2: wait states per OKAY transfer; used only when AHB_SLAVE_WAIT_EN is defined (REQ-024).
REQ-004 SHALL have port hclk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port hresetn, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port hsel_i, input, 1: slave select.
REQ-007 SHALL have port haddr_i, input, AHB_ADDR_WIDTH: byte address.
REQ-008 SHALL have port htrans_i, input, 2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-009 SHALL have ports hwrite_i (1), hsize_i (3), hburst_i (3), hprot_i (4), all inputs; hburst_i and hprot_i are ignored.
REQ-010 SHALL have port hwdata_i, input, 32: write data, valid in data phase.
REQ-011 SHALL have port hready_i, input, 1: bus ready, i.e. the previous transfer completed.
REQ-012 SHALL have ports hreadyout_o (1), hrdata_o (32) and hresp_o (2), all outputs; hresp_o is OKAY=00 or ERROR=01.

Function
REQ-013 SHALL accept an address phase only when hsel_i & hready_i & htrans_i[1] at a rising edge, and SHALL register the address, size and direction.
- IDLE and BUSY transfers, or an unselected slave, SHALL get a zero-wait OKAY response.
REQ-014 SHALL use the FSM states IDLE, WAIT, ERR1, ERR2. Transitions:
- IDLE->WAIT on an accepted legal transfer when the wait count is >0.
- IDLE->ERR1 on an accepted illegal transfer.
- WAIT->IDLE when the wait counter expires.
- ERR1->ERR2 unconditionally.
- ERR2->IDLE, or ERR2->ERR1/WAIT if a new transfer is accepted in ERR2.
REQ-015 SHALL treat a transfer as illegal when any of these holds:
- hsize_i > 3'b010;
- hsize_i=001 and haddr_i[0]=1;
- hsize_i=010 and haddr_i[1:0]!=00;
- word index haddr_i[AW-1:2] >= MEM_DEPTH.
REQ-016 SHALL drive the ERROR response as two cycles:
- ERR1: hreadyout_o=0, hresp_o=01;
- ERR2: hreadyout_o=1, hresp_o=01.
An illegal write SHALL NOT modify memory.
REQ-017 SHALL commit a legal write in the final data-phase cycle (hreadyout_o=1), sampling hwdata_i in that cycle.
- Only the selected lanes are written: byte lane haddr[1:0], halfword lanes haddr[1]*2 and +1, word all four.
REQ-018 SHALL drive hrdata_o in a legal read's final data-phase cycle with the full 32-bit word at the registered index, unshifted, with lanes in place.
- hrdata_o SHALL be 0 otherwise.
REQ-019 SHALL return newly written data to a read that immediately follows a write to the same word.
REQ-020 SHALL hold hresp_o=00 in every state other than ERR1/ERR2.

Reset
REQ-021 SHALL, while hresetn=0, set:
- hreadyout_o=1, hresp_o=00, hrdata_o=0;
- FSM=IDLE, wait counter=0;
- all memory words=0.
REQ-022 SHALL abandon an in-flight transfer when reset asserts mid-WAIT or mid-ERR1, with no memory write.
REQ-023 SHALL accept a transfer on the first rising edge after hresetn deasserts.

Configuration
REQ-024 SHALL, when AHB_SLAVE_WAIT_EN is defined, hold hreadyout_o=0 for exactly WAIT_CYCLES cycles before the OKAY completion cycle of every legal transfer.
- When the macro is undefined, legal transfers SHALL complete with zero wait states, the WAIT state and counter SHALL be absent, and WAIT_CYCLES SHALL be ignored.
REQ-025 SHALL complete with zero wait states when the macro is defined and WAIT_CYCLES=0.

Structure
REQ-026 SHALL place the HTRANS/HRESP/HSIZE encodings and the FSM state enum in the shared package ahb_pkg.
REQ-027 SHALL keep the storage array and byte-lane write logic in one sub-module, ahb_sram_mem; the FSM and decode SHALL stay in the top module.

Verification
REQ-028 SHALL cover: word write 0xDEADBEEF to 0x10, then word read from 0x10 -> hrdata_o=0xDEADBEEF, hresp_o=00, zero waits (macro undefined).
REQ-029 SHALL cover: byte write 0xAA to 0x13 over word 0x11223344 at 0x10 -> read of 0x10 returns 0xAA223344.
REQ-030 SHALL cover: halfword read at 0x01 -> hreadyout_o 0 then 1, hresp_o=01 for both cycles; word read at 0x100 (MEM_DEPTH=64) -> same ERROR response, memory unchanged.
REQ-031 SHALL cover: AHB_SLAVE_WAIT_EN defined, WAIT_CYCLES=2, back-to-back NONSEQ reads -> each shows two hreadyout_o=0 cycles then OKAY data.
REQ-032 SHALL cover: hresetn pulsed low during WAIT of a write to 0x20 -> word 0x20 reads 0x00000000, hreadyout_o=1 immediately on reset.
